ring_phase_monitor: RTL and testbench
=====================================

Name: ring_phase_monitor

Overview:
Downstream consumer of the 4-bit one-hot ring counter output. Samples the ring state every clock and checks that it is one-hot and advances by exactly one rotation per enabled cycle. Encodes the hot position to a binary phase index, counts completed revolutions, and flags and counts sequence faults. Sits between the ring counter and the phase-slot logic that needs a trusted binary phase.

Parameters:
N, 4, ring width (number of phases), N >= 2
DIR, 0, expected rotation: 0 = left (bit i -> bit i+1, bit N-1 -> bit 0); 1 = right
LOCK_CNT, 2, consecutive correct steps required to declare lock, >= 1
REV_W, 8, revolution counter width
ERR_W, 4, error counter width

Ports:
c  input  1  clock, rising edge
r  input  1  reset, asynchronous, active-low (0 = reset)
en  input  1  sample enable; 0 freezes all state
q_in  input  N  ring counter state under test
clr_err  input  1  synchronous clear of err and err_cnt
idx  output  clog2(N)  binary position of the last valid one-hot sample
idx_valid  output  1  last enabled sample was one-hot
locked  output  1  FSM in LOCKED
err  output  1  sticky fault flag
err_pulse  output  1  one-cycle pulse on each detected fault
err_cnt  output  ERR_W  saturating fault count
rev_cnt  output  REV_W  revolutions completed while locked, wraps modulo 2^REV_W

Behaviour:
- Reset (r=0, asynchronous): idx=0, idx_valid=0, locked=0, err=0, err_pulse=0, err_cnt=0, rev_cnt=0. Internal prev sample=0, good count=0, state=SEED. Release is synchronous to the next rising edge of c.
- All outputs are registered. Each output reflects the q_in sampled at the same edge, with 1-cycle latency to the consumer.
- en=0: no sampling. All registers hold, err_pulse=0. clr_err is still honoured.
- onehot = popcount(q_in)==1.
- step_ok = onehot and q_in == rotate(prev, DIR).
- When the sample is one-hot: idx = encoded position and idx_valid=1. Otherwise idx holds and idx_valid=0.
- prev is updated to q_in on every enabled edge.
- FSM (evaluated on enabled edges only):
  - SEED: onehot -> SYNC, good=0. Otherwise stay. No fault is raised in SEED.
  - SYNC:
    - step_ok: good+1. If good+1 == LOCK_CNT, go to LOCKED and assert locked at this edge.
    - Not step_ok but onehot: stay in SYNC, good=0 (the sample becomes the new seed).
    - Not onehot: go to SEED.
    - No fault is raised in SYNC.
  - LOCKED:
    - step_ok: stay.
    - Any violation (repeat value, skipped phase, wrong direction, zero, multi-hot): fault. Go to SYNC (good=0) if the sample is onehot, else to SEED. locked deasserts at this edge.
- Fault: err_pulse=1 for one cycle, err=1 sticky, err_cnt+1 saturating at 2^ERR_W-1.
- clr_err=1: err=0 and err_cnt=0. If a fault is detected on the same edge, the fault wins: err=1, err_cnt=1.
- rev_cnt increments on a step_ok in LOCKED whose sample is the wrap phase: bit 0 for DIR=0, bit N-1 for DIR=1. rev_cnt is never cleared except by reset.
- Reset asserted mid-lock forces all outputs to reset values immediately, with no wait for a clock edge.

Test Plan:
- Reset, en=1, q_in 0001,0010,0100,1000,0001 on consecutive edges -> idx 0,1,2,3,0; idx_valid=1 throughout; locked rises at the edge sampling 0100; rev_cnt=1 after 0001; err=0.
- Locked, then q_in=0011 -> err_pulse=1 for one cycle; err=1, err_cnt=1, locked=0, idx_valid=0, idx holds 3. Follow with 0001,0010,0100 -> relock at 0100.
- Locked at 0010, then q_in=1000 (skip) -> fault, err_cnt+1. FSM in SYNC with 1000 as seed; next 0001,0010 -> locked again.
- Locked, en=0 for 3 cycles with q_in=1111 -> all outputs unchanged, err_pulse=0. en=1 with the correct next phase -> still locked, no fault.
- ERR_W=4: 16 faults -> err_cnt saturates at 15. clr_err alone -> err=0, err_cnt=0. clr_err on the same edge as a fault -> err=1, err_cnt=1.
- r driven low between edges while locked with rev_cnt=5 -> all outputs 0 immediately. After release, the first sample 0001 puts the FSM in SYNC and locked stays 0.

Source files
------------

// File: rtl/ring_phase_monitor.sv
// Watches a one-hot ring counter: encodes its phase, tracks lock on the expected
// rotation, counts revolutions while locked and flags/counts sequence faults.
module ring_phase_monitor #(
    parameter int N        = 4,
    parameter int DIR      = 0,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 4
) (
    input  logic                 c,
    input  logic                 r,
    input  logic                 en,
    input  logic [N-1:0]         q_in,
    input  logic                 clr_err,
    output logic [$clog2(N)-1:0] idx,
    output logic                 idx_valid,
    output logic                 locked,
    output logic                 err,
    output logic                 err_pulse,
    output logic [ERR_W-1:0]     err_cnt,
    output logic [REV_W-1:0]     rev_cnt
);
    localparam int IW   = $clog2(N);
    localparam int GW   = $clog2(LOCK_CNT + 1);
    localparam int WRAP = (DIR != 0) ? N - 1 : 0;

    typedef enum logic [1:0] {SEED, SYNC, LOCKED} state_t;

    state_t          state, state_n;
    logic [GW-1:0]   good, good_n;
    logic [N-1:0]    prev, rot;
    logic [IW-1:0]   pos;
    logic            onehot, step_ok, fault, fault_e, rev_inc;

    assign rot     = (DIR != 0) ? {prev[0], prev[N-1:1]} : {prev[N-2:0], prev[N-1]};
    assign onehot  = $onehot(q_in);
    assign step_ok = onehot && (q_in == rot);
    assign fault_e = en && fault;
    assign locked  = (state == LOCKED);

    always_comb begin
        pos = '0;
        for (int i = 0; i < N; i++)
            if (q_in[i]) pos = IW'(i);
    end

    always_comb begin
        state_n = state;
        good_n  = good;
        fault   = 1'b0;
        rev_inc = 1'b0;
        case (state)
            SEED: begin
                if (onehot) begin
                    state_n = SYNC;
                    good_n  = '0;
                end
            end
            SYNC: begin
                if (step_ok) begin
                    good_n = good + 1'b1;
                    if (good_n == GW'(LOCK_CNT)) state_n = LOCKED;
                end else if (onehot) begin
                    good_n = '0;
                end else begin
                    state_n = SEED;
                end
            end
            LOCKED: begin
                if (step_ok) begin
                    rev_inc = q_in[WRAP];
                end else begin
                    // a one-hot offender becomes the new seed, anything else restarts
                    fault   = 1'b1;
                    good_n  = '0;
                    state_n = onehot ? SYNC : SEED;
                end
            end
            default: state_n = SEED;
        endcase
    end

    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            state     <= SEED;
            good      <= '0;
            prev      <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            rev_cnt   <= '0;
        end else if (en) begin
            state     <= state_n;
            good      <= good_n;
            prev      <= q_in;
            idx_valid <= onehot;
            if (onehot)  idx     <= pos;
            if (rev_inc) rev_cnt <= rev_cnt + 1'b1;
        end
    end

    // fault bookkeeping runs every edge so clr_err works while sampling is frozen
    always_ff @(posedge c or negedge r) begin
        if (!r) begin
            err       <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= fault_e;
            if (fault_e) begin
                err <= 1'b1;
                if (clr_err)        err_cnt <= ERR_W'(1);
                else if (~&err_cnt) err_cnt <= err_cnt + 1'b1;
            end else if (clr_err) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ring_phase_monitor.sv
// Randomized and directed checks of ring_phase_monitor against a phase-index based model.
module tb_ring_phase_monitor;
    localparam int N = 4, DIR = 0, LOCK_CNT = 2, REV_W = 8, ERR_W = 4;

    logic c = 0, r = 0, en = 0, clr_err = 0;
    logic [N-1:0] q_in = '0;
    logic [$clog2(N)-1:0] idx;
    logic idx_valid, locked, err, err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [REV_W-1:0] rev_cnt;

    ring_phase_monitor #(.N(N), .DIR(DIR), .LOCK_CNT(LOCK_CNT), .REV_W(REV_W), .ERR_W(ERR_W)) dut (
        .c(c), .r(r), .en(en), .q_in(q_in), .clr_err(clr_err),
        .idx(idx), .idx_valid(idx_valid), .locked(locked), .err(err),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .rev_cnt(rev_cnt));

    always #5 c = ~c;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // model: chain = length of the current correctly rotating run of one-hot samples
    int  m_chain, m_prev_pos, m_idx, m_ecnt, m_rev;
    bit  m_locked, m_prev_oh, m_iv, m_err, m_pulse;

    function automatic void m_reset();
        m_chain = 0; m_prev_pos = 0; m_idx = 0; m_ecnt = 0; m_rev = 0;
        m_locked = 0; m_prev_oh = 0; m_iv = 0; m_err = 0; m_pulse = 0;
    endfunction

    function automatic void model(input bit e, input logic [N-1:0] q, input bit clr);
        bit oh, ok, fault;
        int pos;
        oh = ($countones(q) == 1);
        pos = 0;
        for (int i = 0; i < N; i++) if (q[i]) pos = i;
        ok = oh && m_prev_oh && (pos == (m_prev_pos + ((DIR != 0) ? N - 1 : 1)) % N);
        fault = 0;
        m_pulse = 0;
        if (e) begin
            if (m_locked) begin
                if (ok) begin
                    if (pos == ((DIR != 0) ? N - 1 : 0)) m_rev = (m_rev + 1) % (1 << REV_W);
                end else begin
                    fault = 1; m_locked = 0; m_chain = oh ? 1 : 0;
                end
            end else if (!oh) m_chain = 0;
            else if (ok && m_chain > 0) begin
                m_chain++;
                if (m_chain - 1 == LOCK_CNT) m_locked = 1;
            end else m_chain = 1;
            if (oh) m_idx = pos;
            m_iv = oh; m_prev_oh = oh; m_prev_pos = pos;
        end
        if (fault) begin
            m_pulse = 1; m_err = 1;
            m_ecnt = clr ? 1 : ((m_ecnt + 1 > (1 << ERR_W) - 1) ? (1 << ERR_W) - 1 : m_ecnt + 1);
        end else if (clr) begin
            m_err = 0; m_ecnt = 0;
        end
    endfunction

    task automatic chk_all(input string tag);
        chk({tag, ".idx"}, 32'(idx), 32'(m_idx));
        chk({tag, ".idx_valid"}, 32'(idx_valid), 32'(m_iv));
        chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
        chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_ecnt));
        chk({tag, ".rev_cnt"}, 32'(rev_cnt), 32'(m_rev));
    endtask

    task automatic step(input string tag, input bit e, input logic [N-1:0] q, input bit clr);
        en = e; q_in = q; clr_err = clr;
        @(posedge c);
        model(e, q, clr);
        @(negedge c);
        chk_all(tag);
    endtask

    function automatic logic [N-1:0] ph(input int p);
        logic [N-1:0] v;
        v = '0;
        v[p % N] = 1'b1;
        return v;
    endfunction

    initial begin
        int pos, sel;
        logic [N-1:0] q;
        m_reset();
        #12;
        chk_all("reset");
        r = 1;
        @(negedge c);

        // clean rotation, lock and first revolution
        for (int i = 0; i < 5; i++) step("rot", 1, ph(i), 0);
        chk("rot.locked_direct", 32'(locked), 1);
        chk("rot.rev_direct", 32'(rev_cnt), 1);

        // multi-hot fault then relock
        step("mh", 1, 4'b0011, 0);
        chk("mh.idx_hold", 32'(idx), 0);
        step("mh2", 1, ph(1), 0);
        chk("mh2.pulse_gone", 32'(err_pulse), 0);
        step("mh3", 1, ph(2), 0);
        step("mh4", 1, ph(3), 0);
        chk("mh4.relock", 32'(locked), 1);

        // skip from 0010 to 1000 while locked
        step("sk0", 1, ph(0), 0);
        step("sk1", 1, ph(1), 0);
        step("skip", 1, ph(3), 0);
        step("sk2", 1, ph(0), 0);
        step("sk3", 1, ph(1), 0);
        chk("sk3.relock", 32'(locked), 1);

        // frozen with garbage input
        for (int i = 0; i < 3; i++) step("frz", 0, 4'b1111, 0);
        step("frz_resume", 1, ph(2), 0);

        // saturate the error counter
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 3; i++) step("sat_lock", 1, ph(i), 0);
            step("sat_fault", 1, 4'b0011, 0);
        end
        chk("sat.err_cnt", 32'(err_cnt), 15);
        step("clr", 1, 4'b0000, 1);
        chk("clr.err_cnt", 32'(err_cnt), 0);
        for (int i = 0; i < 3; i++) step("cf_lock", 1, ph(i), 0);
        step("clr_fault", 1, 4'b0000, 1);
        chk("clr_fault.err_cnt", 32'(err_cnt), 1);
        step("clr_frozen", 0, 4'b0000, 1);

        // randomized traffic
        pos = 0;
        for (int t = 0; t < 600; t++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70)      q = ph(pos + 1);
            else if (sel < 80) q = ph($urandom_range(0, N - 1));
            else if (sel < 90) q = N'($urandom);
            else               q = q_in;
            step("rnd", ($urandom_range(0, 9) != 0), q, ($urandom_range(0, 19) == 0));
            for (int i = 0; i < N; i++) if (q_in[i] && $countones(q_in) == 1) pos = i;
        end

        // asynchronous reset mid-lock with rev_cnt = 5
        r = 0; #1; r = 1; m_reset();
        @(negedge c);
        pos = 0;
        for (int t = 0; t < 100 && m_rev != 5; t++) begin
            step("rev5", 1, ph(pos), 0);
            pos++;
        end
        chk("pre_rst.rev", 32'(rev_cnt), 5);
        chk("pre_rst.locked", 32'(locked), 1);
        @(posedge c);
        #2 r = 0;
        #1;
        m_reset();
        chk_all("async_rst");
        @(negedge c);
        r = 1;
        step("post_rst", 1, ph(0), 0);
        chk("post_rst.locked", 32'(locked), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
